// File: rtl/apple2_video_pkg.sv
// rtl/apple2_video_pkg.sv - shared types, bit positions and helpers for the Apple II video shifter
package apple2_video_pkg;

  typedef enum logic [1:0] {
    MODE_TEXT  = 2'd0,
    MODE_LORES = 2'd1,
    MODE_HIRES = 2'd2
  } mode_e;

  // Counter bits that form horizontal/vertical blanking and the mixed-mode text window
  localparam int HBL_H5_BIT = 5;
  localparam int HBL_H3_BIT = 3;
  localparam int HBL_H4_BIT = 4;
  localparam int VBL_V7_BIT = 7;
  localparam int VBL_V6_BIT = 6;
  localparam int MIX_V5_BIT = 5;

  // Text and hi-res dots last two 14 MHz cycles each, seven per byte
  localparam int DOT_CYCLES    = 2;
  localparam int DOTS_PER_BYTE = 7;

  function automatic mode_e decode_mode(input logic text_sel, input logic hires_sel);
    if (text_sel) begin
      return MODE_TEXT;
    end else if (hires_sel) begin
      return MODE_HIRES;
    end
    return MODE_LORES;
  endfunction

  // Rotate a lo-res nibble right by n positions
  function automatic logic [3:0] rotr4(input logic [3:0] value, input logic [1:0] n);
    logic [7:0] doubled;
    doubled = {value, value} >> n;
    return doubled[3:0];
  endfunction

endpackage

// File: rtl/apple2_dot_shifter.sv
// rtl/apple2_dot_shifter.sv - per-byte dot shift register with dot phase and hi-res half-dot delay
module apple2_dot_shifter
  import apple2_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] mode,
  input  logic [6:0] dots,
  input  logic [3:0] nibble,
  input  logic       odd,
  input  logic       half_delay,
  output logic       dot
);

  localparam logic       PHASE_LAST = 1'(DOT_CYCLES - 1);
  localparam logic [2:0] DOT_LAST   = 3'(DOTS_PER_BYTE - 1);

  mode_e      load_mode;
  mode_e      mode_r;
  logic [6:0] sreg;
  logic [2:0] dot_idx;
  logic       phase;
  logic       delay_q;
  logic       prev_q;

  assign load_mode = mode_e'(mode);

  // During the half-dot delay the previous output is repeated
  always_comb begin
    dot = sreg[0];
    if (delay_q) begin
      dot = prev_q;
    end
  end

  // Shift register: lo-res rotates every cycle, text/hi-res shift every second cycle and stop on the last dot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r  <= MODE_TEXT;
      sreg    <= '0;
      dot_idx <= '0;
      phase   <= 1'b0;
      delay_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      prev_q <= dot;
      if (load) begin
        mode_r  <= load_mode;
        dot_idx <= '0;
        phase   <= 1'b0;
        delay_q <= (load_mode == MODE_HIRES) && half_delay;
        if (load_mode == MODE_LORES) begin
          sreg <= {3'b000, rotr4(nibble, odd ? 2'd2 : 2'd0)};
        end else begin
          sreg <= dots;
        end
      end else if (mode_r == MODE_LORES) begin
        sreg <= {3'b000, sreg[0], sreg[3:1]};
      end else if (delay_q) begin
        delay_q <= 1'b0;
      end else begin
        phase <= ~phase;
        if ((phase == PHASE_LAST) && (dot_idx != DOT_LAST)) begin
          sreg    <= {1'b0, sreg[6:1]};
          dot_idx <= dot_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/apple2_video_shifter.sv
// rtl/apple2_video_shifter.sv - Apple II video byte to 14 MHz monochrome dot stream
module apple2_video_shifter
  import apple2_video_pkg::*;
#(
  parameter int ROW_BITS       = 3,
  parameter int FLASH_DIV_BITS = 4
) (
  input  logic                clock_14Mhz,
  input  logic                RESET_N,
  input  logic                ld194,
  input  logic [6:0]          H,
  input  logic [8:0]          V,
  input  logic [7:0]          VID_DATA,
  input  logic                TEXT_MODE,
  input  logic                MIXED_MODE,
  input  logic                HI_RES,
  output logic [ROW_BITS+5:0] CHR_ADDR,
  input  logic [7:0]          CHR_DATA,
  output logic                VIDEO,
  output logic                BLANK,
  output logic                GR
);

  logic hbl;
  logic vbl;
  logic mixtext;
  logic text_now;

  // Stage L: captured on the byte-load strobe
  logic [7:0]          data_q;
  logic                text_q;
  logic                hires_q;
  logic [ROW_BITS-1:0] row_q;
  logic                nib_sel_q;
  logic                odd_q;
  logic                blank_q;
  logic                ld_q;

  // Stage L+1: held while the character ROM answers
  logic [7:0] data_s;
  logic       text_s;
  logic       hires_s;
  logic       nib_sel_s;
  logic       odd_s;
  logic       blank_s;
  logic       ld_s;

  logic                      vbl_d;
  logic [FLASH_DIV_BITS-1:0] frame_cnt;
  logic                      flash;

  logic       inv;
  logic [6:0] load_dots;
  logic [3:0] load_nibble;
  mode_e      load_mode;
  logic       shifter_dot;
  logic       unused_inputs;

  assign hbl      = ~(H[HBL_H5_BIT] | (H[HBL_H3_BIT] & H[HBL_H4_BIT]));
  assign vbl      = V[VBL_V7_BIT] & V[VBL_V6_BIT];
  assign mixtext  = MIXED_MODE & V[VBL_V7_BIT] & V[MIX_V5_BIT];
  assign text_now = TEXT_MODE | mixtext;
  assign flash    = frame_cnt[FLASH_DIV_BITS-1];

  assign CHR_ADDR = {data_q[5:0], row_q};

  assign unused_inputs = ^{H[6], H[2:1], V[8], V[4:3], CHR_DATA[7]};

  // Stage L capture of the fetched byte and the mode/position context it belongs to
  always_ff @(posedge clock_14Mhz) begin
    if (!RESET_N) begin
      data_q    <= '0;
      text_q    <= 1'b0;
      hires_q   <= 1'b0;
      row_q     <= '0;
      nib_sel_q <= 1'b0;
      odd_q     <= 1'b0;
      blank_q   <= 1'b1;
      ld_q      <= 1'b0;
    end else begin
      ld_q <= ld194;
      if (ld194) begin
        data_q    <= VID_DATA;
        text_q    <= text_now;
        hires_q   <= HI_RES;
        row_q     <= V[ROW_BITS-1:0];
        nib_sel_q <= V[2];
        odd_q     <= H[0];
        blank_q   <= hbl | vbl;
      end
    end
  end

  // Stage L+1 copy so a back-to-back strobe cannot disturb the byte about to be loaded
  always_ff @(posedge clock_14Mhz) begin
    if (!RESET_N) begin
      data_s    <= '0;
      text_s    <= 1'b0;
      hires_s   <= 1'b0;
      nib_sel_s <= 1'b0;
      odd_s     <= 1'b0;
      blank_s   <= 1'b1;
      ld_s      <= 1'b0;
    end else begin
      ld_s <= ld_q;
      if (ld_q) begin
        data_s    <= data_q;
        text_s    <= text_q;
        hires_s   <= hires_q;
        nib_sel_s <= nib_sel_q;
        odd_s     <= odd_q;
        blank_s   <= blank_q;
      end
    end
  end

  // Frame counter advances on each rising edge of vertical blanking and drives the flash phase
  always_ff @(posedge clock_14Mhz) begin
    if (!RESET_N) begin
      vbl_d     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vbl_d <= vbl;
      if (vbl && !vbl_d) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Select what the shifter loads: inverted/flashing glyph row, raw hi-res bits or a lo-res nibble
  always_comb begin
    inv         = ~data_s[7] & (~data_s[6] | flash);
    load_mode   = decode_mode(text_s, hires_s);
    load_dots   = data_s[6:0];
    load_nibble = nib_sel_s ? data_s[7:4] : data_s[3:0];
    if (load_mode == MODE_TEXT) begin
      load_dots = CHR_DATA[6:0] ^ {7{inv}};
    end
  end

  // Blank and colour-burst flags switch together with the first dot of the byte
  always_ff @(posedge clock_14Mhz) begin
    if (!RESET_N) begin
      BLANK <= 1'b1;
      GR    <= 1'b0;
    end else if (ld_s) begin
      BLANK <= blank_s;
      GR    <= ~text_s & ~blank_s;
    end
  end

  apple2_dot_shifter u_dot_shifter (
    .clk        (clock_14Mhz),
    .rst_n      (RESET_N),
    .load       (ld_s),
    .mode       (load_mode),
    .dots       (load_dots),
    .nibble     (load_nibble),
    .odd        (odd_s),
    .half_delay (data_s[7]),
    .dot        (shifter_dot)
  );

  // The shifter keeps running under blanking; only the visible dot is forced low
  always_comb begin
    VIDEO = shifter_dot & ~BLANK;
  end

endmodule

// File: tb/tb_apple2_video_shifter.sv
// tb/tb_apple2_video_shifter.sv - self-checking bench for apple2_video_shifter
module tb_apple2_video_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld;
  logic [6:0] h;
  logic [8:0] v;
  logic [7:0] vid;
  logic       text_mode;
  logic       mixed;
  logic       hires;
  logic [8:0] chr_addr;
  logic [7:0] chr_data;
  logic       video;
  logic       blank;
  logic       gr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int frames = 0;

  typedef struct {
    int         mode;   // 0 text, 1 lo-res, 2 hi-res
    logic [6:0] dots;
    logic [3:0] nib;
    int         rot;
    bit         delay;
    logic       prev;
    bit         blank;
    int         l2;     // cycle index of the edge where the byte reached the output
  } rec_t;

  rec_t prev_r;

  always #5 clk = ~clk;

  apple2_video_shifter dut (
    .clock_14Mhz (clk),
    .RESET_N     (rst_n),
    .ld194       (ld),
    .H           (h),
    .V           (v),
    .VID_DATA    (vid),
    .TEXT_MODE   (text_mode),
    .MIXED_MODE  (mixed),
    .HI_RES      (hires),
    .CHR_ADDR    (chr_addr),
    .CHR_DATA    (chr_data),
    .VIDEO       (video),
    .BLANK       (blank),
    .GR          (gr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic rec_t zero_rec();
    rec_t r;
    r.mode = 2; r.dots = '0; r.nib = '0; r.rot = 0; r.delay = 0;
    r.prev = 1'b0; r.blank = 1; r.l2 = cyc;
    return r;
  endfunction

  // Undelayed dot k cycles after the byte reached the output
  function automatic logic raw_at(rec_t r, int k);
    int j;
    if (r.mode == 1) return r.nib[2'((k + r.rot) % 4)];
    j = k;
    if (r.delay) begin
      if (j == 0) return r.prev;
      j = j - 1;
    end
    j = j / 2;
    if (j > 6) j = 6;
    return r.dots[3'(j)];
  endfunction

  function automatic logic vid_at(rec_t r, int k);
    if (r.blank) return 1'b0;
    return raw_at(r, k);
  endfunction

  function automatic rec_t build(input logic [7:0] d, input logic [7:0] chr, input logic [6:0] hh,
                                 input logic [8:0] vv, input logic tm, input logic mm, input logic hr);
    rec_t r;
    bit text_now, flash_on, inv;
    text_now = tm || (mm && vv[7] && vv[5]);
    flash_on = (frames % 16) >= 8;
    inv      = !d[7] && (!d[6] || flash_on);
    r.mode   = text_now ? 0 : (hr ? 2 : 1);
    r.dots   = text_now ? (chr[6:0] ^ {7{inv}}) : d[6:0];
    r.nib    = vv[2] ? d[7:4] : d[3:0];
    r.rot    = hh[0] ? 2 : 0;
    r.delay  = (r.mode == 2) && d[7];
    r.blank  = !(hh[5] || (hh[3] && hh[4])) || (vv[7] && vv[6]);
    r.prev   = 1'b0;
    r.l2     = 0;
    return r;
  endfunction

  // Random activity on inputs the pipeline must ignore between strobes (vbl kept low)
  task automatic scramble();
    vid       = 8'($urandom);
    text_mode = 1'($urandom);
    mixed     = 1'($urandom);
    hires     = 1'($urandom);
    h         = 7'($urandom);
    v         = 9'($urandom) & 9'h1BF;
    chr_data  = 8'($urandom);
  endtask

  task automatic pulse_vbl();
    v = 9'h0C0;
    tick();
    v = 9'h000;
    tick();
    frames++;
  endtask

  task automatic load_and_check(input logic [7:0] d, input logic [7:0] chr, input logic [6:0] hh,
                                input logic [8:0] vv, input logic tm, input logic mm, input logic hr,
                                input string tag);
    rec_t r;
    logic exp_v;
    logic [8:0] exp_a;
    r = build(d, chr, hh, vv, tm, mm, hr);
    h = hh; v = vv; vid = d; text_mode = tm; mixed = mm; hires = hr; ld = 1'b1;
    tick();
    ld = 1'b0;
    exp_a = {d[5:0], vv[2:0]};
    checks++;
    if (chr_addr !== exp_a) begin
      errors++;
      $display("FAIL %s chr_addr got %h want %h", tag, chr_addr, exp_a);
    end
    scramble();
    tick();
    exp_v = vid_at(prev_r, cyc - prev_r.l2);
    checks++;
    if (video !== exp_v) begin
      errors++;
      $display("FAIL %s early_video got %b want %b", tag, video, exp_v);
    end
    chr_data = chr;
    tick();
    r.prev = raw_at(prev_r, cyc - 1 - prev_r.l2);
    r.l2   = cyc;
    checks++;
    if (blank !== r.blank) begin
      errors++;
      $display("FAIL %s blank got %b want %b", tag, blank, r.blank);
    end
    checks++;
    if (gr !== (r.mode != 0 && !r.blank)) begin
      errors++;
      $display("FAIL %s gr got %b want %b", tag, gr, (r.mode != 0 && !r.blank));
    end
    for (int k = 0; k < 16; k++) begin
      exp_v = vid_at(r, k);
      checks++;
      if (video !== exp_v) begin
        errors++;
        $display("FAIL %s video k=%0d got %b want %b", tag, k, video, exp_v);
      end
      scramble();
      tick();
    end
    prev_r = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld = 1'b0; h = 7'h20; v = 9'h000; vid = 8'h00;
    text_mode = 1'b1; mixed = 1'b0; hires = 1'b0; chr_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({video, blank, gr} !== 3'b010) begin
      errors++;
      $display("FAIL reset_outputs got %b want 010", {video, blank, gr});
    end
    checks++;
    if (chr_addr !== 9'h000) begin
      errors++;
      $display("FAIL reset_chr_addr got %h want 000", chr_addr);
    end
    rst_n = 1'b1;
    frames = 0;
    prev_r = zero_rec();
    tick();
  endtask

  task automatic test_text_glyph();
    load_and_check(8'hC1, 8'h2A, 7'h20, 9'h003, 1'b1, 1'b0, 1'b0, "text_glyph");
    load_and_check(8'h9F, 8'h55, 7'h39, 9'h005, 1'b1, 1'b0, 1'b1, "text_glyph2");
  endtask

  task automatic test_inverse_flash();
    load_and_check(8'h01, 8'h00, 7'h20, 9'h001, 1'b1, 1'b0, 1'b0, "inverse");
    load_and_check(8'h41, 8'h00, 7'h20, 9'h001, 1'b1, 1'b0, 1'b0, "flash_off");
    repeat (8) pulse_vbl();
    load_and_check(8'h41, 8'h00, 7'h20, 9'h001, 1'b1, 1'b0, 1'b0, "flash_on");
    repeat (8) pulse_vbl();
    load_and_check(8'h41, 8'h00, 7'h20, 9'h001, 1'b1, 1'b0, 1'b0, "flash_wrap");
  endtask

  task automatic test_hires();
    load_and_check(8'h00, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_zero");
    load_and_check(8'h7F, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_7f");
    load_and_check(8'hFF, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_ff");
    load_and_check(8'h00, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_zero2");
    load_and_check(8'hFF, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_delay");
    load_and_check(8'hAA, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1, "hires_delay2");
  endtask

  task automatic test_lores();
    load_and_check(8'h5A, 8'h00, 7'h20, 9'h004, 1'b0, 1'b0, 1'b0, "lores_even");
    load_and_check(8'h5A, 8'h00, 7'h21, 9'h004, 1'b0, 1'b0, 1'b0, "lores_odd");
    load_and_check(8'h3C, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b0, "lores_c_even");
    load_and_check(8'h3C, 8'h00, 7'h21, 9'h000, 1'b0, 1'b0, 1'b0, "lores_c_odd");
  endtask

  task automatic test_blank_mixed();
    load_and_check(8'h01, 8'h00, 7'h40, 9'h000, 1'b1, 1'b0, 1'b0, "hblank_text");
    load_and_check(8'h5A, 8'h00, 7'h40, 9'h004, 1'b0, 1'b0, 1'b0, "hblank_lores");
    load_and_check(8'h01, 8'h00, 7'h20, 9'h1A0, 1'b0, 1'b1, 1'b1, "mixed_text");
    load_and_check(8'h01, 8'h00, 7'h20, 9'h080, 1'b0, 1'b1, 1'b1, "mixed_graphics");
  endtask

  task automatic test_back_to_back();
    rec_t ra, rb;
    logic exp_v;
    ra = build(8'h0D, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b0);
    rb = build(8'hFE, 8'h00, 7'h20, 9'h000, 1'b0, 1'b0, 1'b1);
    h = 7'h20; v = 9'h000; vid = 8'h0D; text_mode = 1'b0; mixed = 1'b0; hires = 1'b0; ld = 1'b1;
    tick();
    vid = 8'hFE; hires = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    ra.prev = raw_at(prev_r, cyc - 1 - prev_r.l2);
    ra.l2   = cyc;
    exp_v   = vid_at(ra, 0);
    checks++;
    if (video !== exp_v) begin
      errors++;
      $display("FAIL b2b_first got %b want %b", video, exp_v);
    end
    tick();
    rb.prev = raw_at(ra, cyc - 1 - ra.l2);
    rb.l2   = cyc;
    for (int k = 0; k < 16; k++) begin
      exp_v = vid_at(rb, k);
      checks++;
      if (video !== exp_v) begin
        errors++;
        $display("FAIL b2b_second k=%0d got %b want %b", k, video, exp_v);
      end
      scramble();
      tick();
    end
    prev_r = rb;
  endtask

  task automatic test_random();
    logic [7:0] d, c;
    logic [6:0] hh;
    logic [8:0] vv;
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      c  = 8'($urandom);
      hh = 7'($urandom) | 7'h20;
      vv = 9'($urandom) & 9'h1BF;
      load_and_check(d, c, hh, vv, 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_byte();
    rec_t r;
    r = build(8'h01, 8'h00, 7'h20, 9'h003, 1'b1, 1'b0, 1'b0);
    h = 7'h20; v = 9'h003; vid = 8'h01; text_mode = 1'b1; mixed = 1'b0; hires = 1'b0; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    chr_data = 8'h00;
    tick();
    tick();
    tick();
    checks++;
    if (video !== vid_at(r, 2)) begin
      errors++;
      $display("FAIL pre_reset_video got %b want %b", video, vid_at(r, 2));
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({video, blank, gr} !== 3'b010 || chr_addr !== 9'h000) begin
      errors++;
      $display("FAIL mid_reset got vbg=%b addr=%h want vbg=010 addr=000", {video, blank, gr}, chr_addr);
    end
    rst_n = 1'b1;
    frames = 0;
    prev_r = zero_rec();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (video !== 1'b0 || blank !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d got video=%b blank=%b want 0 1", k, video, blank);
      end
    end
    load_and_check(8'hC1, 8'h2A, 7'h20, 9'h003, 1'b1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_text_glyph();
    test_inverse_flash();
    test_hires();
    test_lores();
    test_back_to_back();
    test_random();
    test_blank_mixed();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
